// File: rtl/mcpu_pkg.sv
// Shared opcode, state and ALU-control encodings for the multicycle controller.
// MCPU_JAL_EN adds JAL to the set of decodable opcodes.
package mcpu_pkg;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_REX  = 4'd6,
        S_RWB  = 4'd7,
        S_IEX  = 4'd8,
        S_IWB  = 4'd9,
        S_BR   = 4'd10,
        S_JMP  = 4'd11,
        S_JAL  = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_ctrl;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
`ifdef MCPU_JAL_EN
            OP_JAL: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mcpu_ctrl_if.sv
// Instruction/handshake inputs and datapath control outputs of the controller.
interface mcpu_ctrl_if #(
    parameter int OPW = 6
);
    logic [OPW-1:0] op;
    logic [OPW-1:0] funct;
    logic           zero;
    logic           mem_ready;

    logic           pc_we;
    logic           ir_we;
    logic           reg_we;
    logic           mem_rd;
    logic           mem_wr;
    logic           iord;
    logic           alu_src_a;
    logic [1:0]     reg_dst;
    logic [1:0]     mem_to_reg;
    logic [1:0]     alu_src_b;
    logic [1:0]     pc_src;
    logic [1:0]     alu_ctrl;
    logic [3:0]     state;
    logic           illegal;

    modport master (
        output op, funct, zero, mem_ready,
        input  pc_we, ir_we, reg_we, mem_rd, mem_wr, iord, alu_src_a,
               reg_dst, mem_to_reg, alu_src_b, pc_src, alu_ctrl, state, illegal
    );

    modport slave (
        input  op, funct, zero, mem_ready,
        output pc_we, ir_we, reg_we, mem_rd, mem_wr, iord, alu_src_a,
               reg_dst, mem_to_reg, alu_src_b, pc_src, alu_ctrl, state, illegal
    );
endinterface

// File: rtl/mcpu_ctrl_dec.sv
// Combinational Moore output decode: state (plus op/zero/mem_ready qualifiers) to controls.
// MCPU_JAL_EN enables the JAL state outputs.
module mcpu_ctrl_dec
    import mcpu_pkg::*;
#(
    parameter int OPW = 6
) (
    input  state_t         state,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    input  logic           mem_ready,
    output ctrl_t          ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_IF: begin
                ctrl.mem_rd    = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.pc_we     = mem_ready;
                ctrl.ir_we     = mem_ready;
            end
            S_ID: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.illegal   = ~op_legal(op);
            end
            S_MADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            S_MRD: begin
                ctrl.mem_rd = 1'b1;
                ctrl.iord   = 1'b1;
            end
            S_MWR: begin
                ctrl.mem_wr = 1'b1;
                ctrl.iord   = 1'b1;
            end
            S_MWB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.mem_to_reg = 2'b01;
            end
            S_REX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_ctrl  = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_we  = 1'b1;
                ctrl.reg_dst = 2'b01;
            end
            S_IEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_ctrl  = (op == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            S_IWB: ctrl.reg_we = 1'b1;
            S_BR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_ctrl  = ALU_SUB;
                ctrl.pc_src    = 2'b01;
                ctrl.pc_we     = (op == OP_BNE) ? ~zero : zero;
            end
            S_JMP: begin
                ctrl.pc_src = 2'b10;
                ctrl.pc_we  = 1'b1;
            end
`ifdef MCPU_JAL_EN
            S_JAL: begin
                ctrl.pc_src     = 2'b10;
                ctrl.pc_we      = 1'b1;
                ctrl.reg_we     = 1'b1;
                ctrl.reg_dst    = 2'b10;
                ctrl.mem_to_reg = 2'b10;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multicycle CPU control FSM; outputs come from mcpu_ctrl_dec, enables masked during reset.
// MCPU_JAL_EN adds the JAL instruction (state JAL); otherwise opcode 000011 is illegal.
//
//   state | meaning
//   IF    | fetch, wait for mem_ready
//   ID    | decode, precompute branch target
//   MADR  | load/store address
//   MRD   | load memory read, wait for mem_ready
//   MWB   | load register write-back
//   MWR   | store memory write, wait for mem_ready
//   REX   | R-type execute
//   RWB   | R-type write-back
//   IEX   | ADDI/ORI execute
//   IWB   | ADDI/ORI write-back
//   BR    | BEQ/BNE compare and conditional PC update
//   JMP   | jump
//   JAL   | jump-and-link (only with MCPU_JAL_EN)
module mcpu_ctrl
    import mcpu_pkg::*;
#(
    parameter int OPW = 6
) (
    input logic        clk,
    input logic        rst,
    mcpu_ctrl_if.slave bus
);

    state_t state;
    ctrl_t  ctrl;
    logic   unused_funct;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IF;
        end else begin
            case (state)
                S_IF: if (bus.mem_ready) state <= S_ID;
                S_ID: begin
                    case (bus.op)
                        OP_LW, OP_SW:    state <= S_MADR;
                        OP_R:            state <= S_REX;
                        OP_ADDI, OP_ORI: state <= S_IEX;
                        OP_BEQ, OP_BNE:  state <= S_BR;
                        OP_J:            state <= S_JMP;
`ifdef MCPU_JAL_EN
                        OP_JAL:          state <= S_JAL;
`endif
                        default:         state <= S_IF;
                    endcase
                end
                S_MADR: begin
                    if (bus.op == OP_LW)      state <= S_MRD;
                    else if (bus.op == OP_SW) state <= S_MWR;
                    else                      state <= S_IF;
                end
                S_MRD:  if (bus.mem_ready) state <= S_MWB;
                S_MWR:  if (bus.mem_ready) state <= S_IF;
                S_REX:  state <= S_RWB;
                S_IEX:  state <= S_IWB;
                // every single-cycle terminal state returns to fetch
                default: state <= S_IF;
            endcase
        end
    end

    mcpu_ctrl_dec #(.OPW(OPW)) u_dec (
        .state     (state),
        .op        (bus.op),
        .zero      (bus.zero),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    // IF decodes mem_rd and mem_ready-driven enables, so reset must mask them directly
    assign bus.pc_we      = ctrl.pc_we   & ~rst;
    assign bus.ir_we      = ctrl.ir_we   & ~rst;
    assign bus.reg_we     = ctrl.reg_we  & ~rst;
    assign bus.mem_rd     = ctrl.mem_rd  & ~rst;
    assign bus.mem_wr     = ctrl.mem_wr  & ~rst;
    assign bus.illegal    = ctrl.illegal & ~rst;
    assign bus.iord       = ctrl.iord;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.alu_ctrl   = ctrl.alu_ctrl;
    assign bus.state      = state;

    assign unused_funct = ^bus.funct;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Self-checking bench for mcpu_ctrl: instruction-level reference model, random and directed cases.
module tb_mcpu_ctrl;
    import mcpu_pkg::*;

    localparam logic [5:0] C_R = 6'b000000, C_J = 6'b000010, C_JAL = 6'b000011;
    localparam logic [5:0] C_BEQ = 6'b000100, C_BNE = 6'b000101, C_ADDI = 6'b001000;
    localparam logic [5:0] C_ORI = 6'b001101, C_LW = 6'b100011, C_SW = 6'b101011;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_ctrl;
        logic       illegal;
    } exp_t;

    typedef state_t st_q_t[$];

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    mcpu_ctrl_if #(.OPW(6)) bus ();
    mcpu_ctrl #(.OPW(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t   got;
    exp_t   exp_vec;
    state_t exp_state;
    logic   chk_en = 1'b0;
    int     tr_state[$], tr_regwe[$], tr_regdst[$], tr_memwr[$];
    int     tr_pcwe[$], tr_pcsrc[$], tr_illegal[$];

    assign got = {bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_rd, bus.mem_wr, bus.iord,
                  bus.alu_src_a, bus.reg_dst, bus.mem_to_reg, bus.alu_src_b, bus.pc_src,
                  bus.alu_ctrl, bus.illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    function automatic logic is_legal(input logic [5:0] o);
`ifdef MCPU_JAL_EN
        return o inside {C_R, C_J, C_JAL, C_BEQ, C_BNE, C_ADDI, C_ORI, C_LW, C_SW};
`else
        return o inside {C_R, C_J, C_BEQ, C_BNE, C_ADDI, C_ORI, C_LW, C_SW};
`endif
    endfunction

    // the sequence of states an instruction walks through, ignoring memory waits
    function automatic st_q_t phases(input logic [5:0] o);
        st_q_t q;
        q.push_back(S_IF);
        q.push_back(S_ID);
        if (o == C_LW)                        q = {q, S_MADR, S_MRD, S_MWB};
        else if (o == C_SW)                   q = {q, S_MADR, S_MWR};
        else if (o == C_R)                    q = {q, S_REX, S_RWB};
        else if (o == C_ADDI || o == C_ORI)   q = {q, S_IEX, S_IWB};
        else if (o == C_BEQ || o == C_BNE)    q.push_back(S_BR);
        else if (o == C_J)                    q.push_back(S_JMP);
`ifdef MCPU_JAL_EN
        else if (o == C_JAL)                  q.push_back(S_JAL);
`endif
        return q;
    endfunction

    function automatic exp_t exp_out(input state_t s, input logic [5:0] o, input logic z,
                                     input logic mr);
        exp_t e = '0;
        case (s)
            S_IF:   begin e.mem_rd = 1; e.alu_src_b = 2'b01; e.pc_we = mr; e.ir_we = mr; end
            S_ID:   begin e.alu_src_b = 2'b11; e.illegal = !is_legal(o); end
            S_MADR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            S_MRD:  begin e.mem_rd = 1; e.iord = 1; end
            S_MWR:  begin e.mem_wr = 1; e.iord = 1; end
            S_MWB:  begin e.reg_we = 1; e.mem_to_reg = 2'b01; end
            S_REX:  begin e.alu_src_a = 1; e.alu_ctrl = 2'b10; end
            S_RWB:  begin e.reg_we = 1; e.reg_dst = 2'b01; end
            S_IEX:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10;
                          e.alu_ctrl = (o == C_ORI) ? 2'b11 : 2'b00; end
            S_IWB:  e.reg_we = 1;
            S_BR:   begin e.alu_src_a = 1; e.alu_ctrl = 2'b01; e.pc_src = 2'b01;
                          e.pc_we = (o == C_BNE) ? !z : z; end
            S_JMP:  begin e.pc_src = 2'b10; e.pc_we = 1; end
            S_JAL:  begin e.pc_src = 2'b10; e.pc_we = 1; e.reg_we = 1;
                          e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            tr_state.push_back(int'(bus.state));
            tr_regwe.push_back(int'(bus.reg_we));
            tr_regdst.push_back(int'(bus.reg_dst));
            tr_memwr.push_back(int'(bus.mem_wr));
            tr_pcwe.push_back(int'(bus.pc_we));
            tr_pcsrc.push_back(int'(bus.pc_src));
            tr_illegal.push_back(int'(bus.illegal));
            if (got !== exp_vec || bus.state !== 4'(exp_state)) begin
                n_fail++;
                $display("FAIL cycle t=%0t: state got %0d want %0d, outputs got %h want %h",
                         $time, bus.state, exp_state, got, exp_vec);
            end
        end
    end

    task automatic check(input string name, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    function automatic int count_of(input int q[$], input int v);
        int c = 0;
        foreach (q[i]) if (q[i] == v) c++;
        return c;
    endfunction

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // entered and left at 1 time unit after a rising edge
    task automatic run_instr(input logic [5:0] opc, input logic zv, input int wait_if,
                             input int wait_mem, input int abort_at, output int ncyc);
        st_q_t ph;
        int    waits;
        logic  mem_phase;
        logic  mr;
        ph   = phases(opc);
        ncyc = 0;
        tr_state.delete(); tr_regwe.delete(); tr_regdst.delete(); tr_memwr.delete();
        tr_pcwe.delete(); tr_pcsrc.delete(); tr_illegal.delete();
        foreach (ph[i]) begin
            mem_phase = ph[i] inside {S_IF, S_MRD, S_MWR};
            waits = (ph[i] == S_IF) ? wait_if : (mem_phase ? wait_mem : 0);
            for (int w = 0; w <= waits; w++) begin
                if (abort_at >= 0 && ncyc == abort_at) begin
                    chk_en = 1'b0;
                    return;
                end
                mr            = mem_phase ? logic'(w == waits) : 1'($urandom_range(0, 1));
                bus.op        = (ph[i] == S_IF) ? 6'($urandom) : opc;
                bus.funct     = 6'($urandom);
                bus.zero      = zv;
                bus.mem_ready = mr;
                exp_state     = ph[i];
                exp_vec       = exp_out(ph[i], opc, zv, mr);
                chk_en        = 1'b1;
                @(posedge clk);
                #1;
                ncyc++;
            end
        end
        chk_en = 1'b0;
    endtask

    logic [5:0] pool [10];
    int         n;
    int         r_seq [4];
    logic [5:0] opc;

    initial begin
        pool = '{C_R, C_LW, C_SW, C_ADDI, C_ORI, C_BEQ, C_BNE, C_J, C_JAL, 6'b111111};
        r_seq = '{int'(S_IF), int'(S_ID), int'(S_REX), int'(S_RWB)};
        rst = 1'b1;
        bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

        @(posedge clk); #1;
        check("rst_state", int'(bus.state), int'(S_IF));
        check("rst_enables", int'({bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_rd,
                                   bus.mem_wr, bus.illegal}), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_instr(C_R, 1'b0, 0, 0, -1, n);
        check("r_len", n, 4);
        for (int i = 0; i < 4; i++) check("r_seq", at(tr_state, i), r_seq[i]);
        check("r_regwe_cnt", count_of(tr_regwe, 1), 1);
        check("r_regwe_rwb", at(tr_regwe, 3), 1);
        check("r_regdst_rwb", at(tr_regdst, 3), 1);
        check("r_next_if", int'(bus.state), int'(S_IF));

        run_instr(C_LW, 1'b0, 0, 3, -1, n);
        check("lw_len", n, 8);
        check("lw_mrd_cycles", count_of(tr_state, int'(S_MRD)), 4);
        check("lw_no_memwr", count_of(tr_memwr, 1), 0);

        run_instr(C_BEQ, 1'b1, 0, 0, -1, n);
        check("beq_z1_len", n, 3);
        check("beq_z1_pcwe", at(tr_pcwe, 2), 1);
        check("beq_z1_pcsrc", at(tr_pcsrc, 2), 1);
        run_instr(C_BEQ, 1'b0, 0, 0, -1, n);
        check("beq_z0_pcwe", at(tr_pcwe, 2), 0);
        run_instr(C_BNE, 1'b1, 0, 0, -1, n);
        check("bne_z1_pcwe", at(tr_pcwe, 2), 0);
        run_instr(C_BNE, 1'b0, 1, 0, -1, n);
        check("bne_z0_len", n, 4);
        check("bne_z0_pcwe", at(tr_pcwe, 3), 1);

        run_instr(6'b111111, 1'b0, 0, 0, -1, n);
        check("ill_len", n, 2);
        check("ill_if", at(tr_illegal, 0), 0);
        check("ill_id", at(tr_illegal, 1), 1);
        check("ill_no_regwe", count_of(tr_regwe, 1), 0);
        check("ill_no_memwr", count_of(tr_memwr, 1), 0);
        check("ill_next_if", int'(bus.state), int'(S_IF));

        run_instr(C_JAL, 1'b0, 0, 0, -1, n);
`ifdef MCPU_JAL_EN
        check("jal_len", n, 3);
        check("jal_state", at(tr_state, 2), int'(S_JAL));
        check("jal_regwe", at(tr_regwe, 2), 1);
        check("jal_pcsrc", at(tr_pcsrc, 2), 2);
`else
        check("jal_len", n, 2);
        check("jal_illegal", at(tr_illegal, 1), 1);
`endif

        // store stalled in MWR, then reset lands between clock edges
        run_instr(C_SW, 1'b0, 0, 5, 5, n);
        check("mwr_state", int'(bus.state), int'(S_MWR));
        check("mwr_wr", int'(bus.mem_wr), 1);
        #2 rst = 1'b1;
        #1;
        check("mwr_rst_wr", int'(bus.mem_wr), 0);
        check("mwr_rst_state", int'(bus.state), int'(S_IF));
        check("mwr_rst_rd", int'(bus.mem_rd), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check("post_rst_state", int'(bus.state), int'(S_IF));
        check("post_rst_fetch", int'(bus.mem_rd), 1);
        check("post_rst_no_wr", int'(bus.mem_wr), 0);

        for (int k = 0; k < 250; k++) begin
            opc = ($urandom_range(0, 9) == 0) ? 6'($urandom) : pool[$urandom_range(0, 9)];
            run_instr(opc, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      $urandom_range(0, 3), -1, n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
